// File: rtl/kpd_scan_fifo.sv
`default_nettype none
// ============================================================================
// Module      : kpd_scan_fifo
// Description : Matrix keypad scanner with per-key debounce and a press-event
//               FIFO read through a valid/ready handshake. Define
//               KPD_HEXMAP_EN (4x4 only) to push hex-pad legend codes.
// Revision    : 1.0  initial release
// ============================================================================
module kpd_scan_fifo #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter int CODE_W         = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              slow_clk,
  input  logic              rst,
  output logic [COLS-1:0]   col_n,
  input  logic [ROWS-1:0]   row_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_any,
  output logic              overflow
);

  localparam int c_num_keys = ROWS * COLS;
  localparam int c_row_w    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int c_col_w    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int c_set_w    = $clog2(SETTLE_CYCLES + 1);
  localparam int c_ptr_w    = $clog2(FIFO_DEPTH);
  localparam int c_dbc_w    = 4;

  typedef enum logic [1:0] {
    S_DRIVE  = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_col_w-1:0]   r_col;
  logic [c_row_w-1:0]   r_row;
  logic [c_set_w-1:0]   r_settle;
  logic [c_num_keys-1:0] r_stable;
  logic [c_dbc_w-1:0]   r_dbc [c_num_keys];
  logic [CODE_W-1:0]    r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w:0]     r_count;

  logic                 w_last_row;
  logic                 w_last_col;
  logic                 w_settle_done;
  logic                 w_sampling;
  logic [CODE_W-1:0]    w_idx;
  logic                 w_raw;
  logic                 w_stable_bit;
  logic [c_dbc_w-1:0]   w_dbc;
  logic                 w_flip;
  logic                 w_push;
  logic [CODE_W-1:0]    w_push_code;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_push_ok;
  logic [c_ptr_w-1:0]   w_rd_nxt;
  logic [c_ptr_w:0]     w_left;
  logic [c_ptr_w:0]     w_count_nxt;
  logic [CODE_W-1:0]    w_head_nxt;

`ifdef KPD_HEXMAP_EN
  generate
    if (ROWS != 4 || COLS != 4) begin : g_hexmap_bad_dims
      $error("KPD_HEXMAP_EN requires ROWS == 4 and COLS == 4");
    end
  endgenerate

  function automatic logic [CODE_W-1:0] f_code(input logic [CODE_W-1:0] idx);
    case (idx)
      CODE_W'(0):  f_code = CODE_W'(4'h1);
      CODE_W'(1):  f_code = CODE_W'(4'h2);
      CODE_W'(2):  f_code = CODE_W'(4'h3);
      CODE_W'(3):  f_code = CODE_W'(4'hA);
      CODE_W'(4):  f_code = CODE_W'(4'h4);
      CODE_W'(5):  f_code = CODE_W'(4'h5);
      CODE_W'(6):  f_code = CODE_W'(4'h6);
      CODE_W'(7):  f_code = CODE_W'(4'hB);
      CODE_W'(8):  f_code = CODE_W'(4'h7);
      CODE_W'(9):  f_code = CODE_W'(4'h8);
      CODE_W'(10): f_code = CODE_W'(4'h9);
      CODE_W'(11): f_code = CODE_W'(4'hC);
      CODE_W'(12): f_code = CODE_W'(4'h0);
      CODE_W'(13): f_code = CODE_W'(4'hF);
      CODE_W'(14): f_code = CODE_W'(4'hE);
      default:     f_code = CODE_W'(4'hD);
    endcase
  endfunction
`else
  function automatic logic [CODE_W-1:0] f_code(input logic [CODE_W-1:0] idx);
    f_code = idx;
  endfunction
`endif

  assign w_last_row    = (r_row == c_row_w'(ROWS - 1));
  assign w_last_col    = (r_col == c_col_w'(COLS - 1));
  assign w_settle_done = (r_settle == '0);

  // ---------------- scan sequencer ----------------
  always_ff @(posedge slow_clk) begin
    if (rst) r_state <= S_DRIVE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_DRIVE:  w_state_nxt = S_SETTLE;
      S_SETTLE: if (w_settle_done) w_state_nxt = S_SAMPLE;
      S_SAMPLE: if (w_last_row) w_state_nxt = S_DRIVE;
      default:  w_state_nxt = S_DRIVE;
    endcase
  end

  always_ff @(posedge slow_clk) begin
    if (rst) begin
      col_n    <= '1;
      r_col    <= '0;
      r_row    <= '0;
      r_settle <= '0;
    end else begin
      case (r_state)
        S_DRIVE: begin
          col_n    <= ~(COLS'(1) << r_col);
          r_settle <= c_set_w'(SETTLE_CYCLES - 1);
          r_row    <= '0;
        end
        S_SETTLE: begin
          if (!w_settle_done) r_settle <= r_settle - c_set_w'(1);
        end
        S_SAMPLE: begin
          if (w_last_row) begin
            r_row <= '0;
            r_col <= w_last_col ? '0 : r_col + c_col_w'(1);
          end else begin
            r_row <= r_row + c_row_w'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- per-key debounce, one key per sample slot ----------------
  assign w_sampling   = (r_state == S_SAMPLE);
  assign w_idx        = CODE_W'(int'(r_row) * COLS + int'(r_col));
  assign w_raw        = ~row_n[r_row];
  assign w_stable_bit = r_stable[w_idx];
  assign w_dbc        = r_dbc[w_idx];
  assign w_flip       = w_sampling && (w_raw != w_stable_bit)
                        && (w_dbc == c_dbc_w'(DEBOUNCE_SCANS - 1));
  assign w_push       = w_flip && w_raw;
  assign w_push_code  = f_code(w_idx);

  always_ff @(posedge slow_clk) begin
    if (rst) begin
      r_stable <= '0;
      key_any  <= 1'b0;
      for (int i = 0; i < c_num_keys; i++) r_dbc[i] <= '0;
    end else begin
      key_any <= |r_stable;
      if (w_sampling) begin
        if (w_raw == w_stable_bit) begin
          r_dbc[w_idx] <= '0;
        end else if (w_flip) begin
          r_stable[w_idx] <= w_raw;
          r_dbc[w_idx]    <= '0;
        end else begin
          r_dbc[w_idx] <= w_dbc + c_dbc_w'(1);
        end
      end
    end
  end

  // ---------------- event FIFO ----------------
  assign w_pop       = key_valid && key_ready;
  assign w_full      = (r_count == (c_ptr_w + 1)'(FIFO_DEPTH));
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign w_rd_nxt    = w_pop ? r_rd_ptr + c_ptr_w'(1) : r_rd_ptr;
  assign w_left      = r_count - (c_ptr_w + 1)'(w_pop);
  assign w_count_nxt = w_left + (c_ptr_w + 1)'(w_push_ok);

  // Head register looks ahead so key_code is valid the same clock as key_valid.
  always_comb begin
    w_head_nxt = key_code;
    if (w_left != '0)   w_head_nxt = r_mem[w_rd_nxt];
    else if (w_push_ok) w_head_nxt = w_push_code;
  end

  always_ff @(posedge slow_clk) begin
    if (!rst && w_push_ok) r_mem[r_wr_ptr] <= w_push_code;
  end

  always_ff @(posedge slow_clk) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      overflow  <= 1'b0;
    end else begin
      r_rd_ptr  <= w_rd_nxt;
      r_count   <= w_count_nxt;
      key_valid <= (w_count_nxt != '0);
      key_code  <= w_head_nxt;
      if (w_push_ok)          r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_push && !w_push_ok) overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kpd_scan_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_kpd_scan_fifo
// Description : Bench for kpd_scan_fifo with a keypad matrix model and a
//               frame-schedule reference model of debounce and event queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_kpd_scan_fifo;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int SETTLE = 2;
  localparam int DEB    = 3;
  localparam int DEPTH  = 4;
  localparam int CW     = 4;
  localparam int PER    = 1 + SETTLE + ROWS;
  localparam int FRAME  = COLS * PER;
  localparam int NKEYS  = ROWS * COLS;

  logic            slow_clk = 1'b0;
  logic            rst = 1'b1;
  logic [COLS-1:0] col_n;
  logic [ROWS-1:0] row_n;
  logic [CW-1:0]   key_code;
  logic            key_valid;
  logic            key_ready = 1'b0;
  logic            key_any;
  logic            overflow;

  logic [COLS-1:0] kp [ROWS];

  int errors = 0;
  int checks = 0;

  bit              m_stable [NKEYS];
  int              m_dbc    [NKEYS];
  int              m_q[$];
  bit              m_ovf;
  bit              m_any;
  int              m_k;
  logic [COLS-1:0] m_col_n;
  int              dut_pops[$];

`ifdef KPD_HEXMAP_EN
  int hex_tbl [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
`endif

  kpd_scan_fifo #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(SETTLE),
    .DEBOUNCE_SCANS(DEB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .slow_clk (slow_clk),
    .rst      (rst),
    .col_n    (col_n),
    .row_n    (row_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_any  (key_any),
    .overflow (overflow)
  );

  always #5 slow_clk = ~slow_clk;

  // Passive matrix: a row reads low when a closed key sits on a driven column.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < ROWS; r++) row_n[r] = ~|(kp[r] & ~col_n);
  end

  function automatic int legend(int r, int c);
`ifdef KPD_HEXMAP_EN
    return hex_tbl[r * COLS + c];
`else
    return r * COLS + c;
`endif
  endfunction

  function automatic logic [COLS+2:0] m_obs();
    return {m_col_n, (m_q.size() != 0), m_any, m_ovf};
  endfunction

  task automatic release_all();
    for (int r = 0; r < ROWS; r++) kp[r] = '0;
  endtask

  // Advance one clock: update the reference model from the inputs the DUT sees.
  task automatic step();
    int ph, c, r, idx;
    bit raw, push, pop, full, any_prev;
    if (!rst && key_valid && key_ready) dut_pops.push_back(int'(key_code));
    if (rst) begin
      for (int i = 0; i < NKEYS; i++) begin
        m_stable[i] = 1'b0;
        m_dbc[i]    = 0;
      end
      m_q.delete();
      m_ovf   = 1'b0;
      m_any   = 1'b0;
      m_k     = 0;
      m_col_n = '1;
    end else begin
      ph = m_k % PER;
      c  = (m_k / PER) % COLS;
      r  = 0;
      push = 1'b0;
      any_prev = 1'b0;
      for (int i = 0; i < NKEYS; i++) any_prev |= m_stable[i];
      if (ph == 0) m_col_n = ~(COLS'(1) << c);
      if (ph > SETTLE) begin
        r   = ph - SETTLE - 1;
        idx = r * COLS + c;
        raw = kp[r][c];
        if (raw == m_stable[idx]) m_dbc[idx] = 0;
        else if (m_dbc[idx] == DEB - 1) begin
          m_stable[idx] = raw;
          m_dbc[idx]    = 0;
          push          = raw;
        end else m_dbc[idx]++;
      end
      pop  = (m_q.size() > 0) && key_ready;
      full = (m_q.size() == DEPTH);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (!full || pop) m_q.push_back(legend(r, c));
        else m_ovf = 1'b1;
      end
      m_any = any_prev;
      m_k++;
    end
    @(posedge slow_clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    dut_pops.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (col_n !== 4'hF)   begin errors++; $display("FAIL reset_col_n got=%h exp=f", col_n); end
    checks++; if (key_valid !== 0)  begin errors++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
    checks++; if (key_code !== 0)   begin errors++; $display("FAIL reset_code got=%h exp=0", key_code); end
    checks++; if (key_any !== 0)    begin errors++; $display("FAIL reset_any got=%b exp=0", key_any); end
    checks++; if (overflow !== 0)   begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    rst = 1'b0;
    dut_pops.delete();
  endtask

  task automatic test_idle();
    logic [3:0] walk [4];
    walk = '{4'hE, 4'hD, 4'hB, 4'h7};
    release_all();
    key_ready = 1'b0;
    for (int i = 0; i < 5 * FRAME; i++) begin
      step();
      checks++;
      if ({col_n, key_valid, key_any, overflow} !== m_obs()) begin
        errors++; $display("FAIL idle_cycle k=%0d got=%b exp=%b", m_k, {col_n, key_valid, key_any, overflow}, m_obs());
      end
      if ((m_k - 1) % PER == 0) begin
        checks++;
        if (col_n !== walk[((m_k - 1) / PER) % 4]) begin
          errors++; $display("FAIL idle_walk k=%0d got=%h exp=%h", m_k, col_n, walk[((m_k - 1) / PER) % 4]);
        end
      end
    end
  endtask

  task automatic test_single_hold();
    int first_valid = -1;
    apply_reset();
    key_ready = 1'b1;
    kp[1][2] = 1'b1;
    for (int i = 0; i < 10 * FRAME; i++) begin
      if (i == 5 * FRAME) release_all();
      step();
      if (key_valid === 1'b1 && first_valid < 0) first_valid = m_k;
      checks++;
      if ({col_n, key_valid, key_any, overflow} !== m_obs()) begin
        errors++; $display("FAIL hold_cycle k=%0d got=%b exp=%b", m_k, {col_n, key_valid, key_any, overflow}, m_obs());
      end
      if (m_q.size() > 0) begin
        checks++;
        if (key_code !== CW'(m_q[0])) begin errors++; $display("FAIL hold_code got=%h exp=%h", key_code, m_q[0]); end
      end
    end
    checks++;
    if (first_valid != 2 * FRAME + 2 * PER + SETTLE + 3) begin
      errors++; $display("FAIL hold_latency got=%0d exp=%0d", first_valid, 2 * FRAME + 2 * PER + SETTLE + 3);
    end
    checks++;
    if (dut_pops.size() != 1 || dut_pops[0] != legend(1, 2)) begin
      errors++; $display("FAIL hold_events got_n=%0d exp_n=1 exp_code=%0d", dut_pops.size(), legend(1, 2));
    end
    checks++; if (key_any !== 1'b0) begin errors++; $display("FAIL hold_released_any got=%b exp=0", key_any); end
  endtask

  task automatic test_glitch();
    apply_reset();
    key_ready = 1'b1;
    kp[0][0] = 1'b1;
    for (int i = 0; i < 6 * FRAME; i++) begin
      if (i == 2 * FRAME) release_all();
      step();
      checks++;
      if ({col_n, key_valid, key_any, overflow} !== m_obs()) begin
        errors++; $display("FAIL glitch_cycle k=%0d got=%b exp=%b", m_k, {col_n, key_valid, key_any, overflow}, m_obs());
      end
      checks++;
      if (key_any !== 1'b0) begin errors++; $display("FAIL glitch_any k=%0d got=%b exp=0", m_k, key_any); end
    end
    checks++;
    if (dut_pops.size() != 0) begin errors++; $display("FAIL glitch_events got=%0d exp=0", dut_pops.size()); end
  endtask

  task automatic test_overflow();
    int rr [5] = '{0, 1, 2, 3, 0};
    int cc [5] = '{0, 1, 2, 3, 3};
    apply_reset();
    key_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      kp[rr[k]][cc[k]] = 1'b1;
      for (int i = 0; i < 8 * FRAME; i++) begin
        if (i == 4 * FRAME) release_all();
        step();
        checks++;
        if ({col_n, key_valid, key_any, overflow} !== m_obs()) begin
          errors++; $display("FAIL ovf_cycle k=%0d got=%b exp=%b", m_k, {col_n, key_valid, key_any, overflow}, m_obs());
        end
        if (m_q.size() > 0) begin
          checks++;
          if (key_code !== CW'(m_q[0])) begin errors++; $display("FAIL ovf_code got=%h exp=%h", key_code, m_q[0]); end
        end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    key_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if ({col_n, key_valid, key_any, overflow} !== m_obs()) begin
        errors++; $display("FAIL ovf_drain k=%0d got=%b exp=%b", m_k, {col_n, key_valid, key_any, overflow}, m_obs());
      end
    end
    checks++;
    if (dut_pops.size() != 4) begin
      errors++; $display("FAIL ovf_pop_count got=%0d exp=4", dut_pops.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (dut_pops[k] != legend(rr[k], cc[k])) begin
          errors++; $display("FAIL ovf_pop%0d got=%0d exp=%0d", k, dut_pops[k], legend(rr[k], cc[k]));
        end
      end
    end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%b exp=0", key_valid); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    key_ready = 1'b0;
    kp[0][1] = 1'b1;
    kp[3][1] = 1'b1;
    for (int i = 0; i < 8 * FRAME; i++) begin
      if (i == 4 * FRAME) key_ready = 1'b1;
      if (i == 4 * FRAME + 6) release_all();
      step();
      checks++;
      if ({col_n, key_valid, key_any, overflow} !== m_obs()) begin
        errors++; $display("FAIL simul_cycle k=%0d got=%b exp=%b", m_k, {col_n, key_valid, key_any, overflow}, m_obs());
      end
      if (m_q.size() > 0) begin
        checks++;
        if (key_code !== CW'(m_q[0])) begin errors++; $display("FAIL simul_code got=%h exp=%h", key_code, m_q[0]); end
      end
    end
    checks++;
    if (dut_pops.size() != 2 || dut_pops[0] != legend(0, 1) || dut_pops[1] != legend(3, 1)) begin
      errors++; $display("FAIL simul_order got_n=%0d exp=%0d,%0d", dut_pops.size(), legend(0, 1), legend(3, 1));
    end
  endtask

  task automatic test_hexmap_reset_mid();
    logic [CW-1:0] exp_hex;
`ifdef KPD_HEXMAP_EN
    exp_hex = 4'hF;
`else
    exp_hex = 4'd13;
`endif
    apply_reset();
    key_ready = 1'b0;
    kp[3][1] = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) step();
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL hex_valid got=%b exp=1", key_valid); end
    checks++; if (key_code !== exp_hex) begin errors++; $display("FAIL hex_code got=%h exp=%h", key_code, exp_hex); end
    kp[2][0] = 1'b1;
    for (int i = 0; i < 2 * FRAME - 3; i++) step();
    rst = 1'b1;
    kp[3][1] = 1'b0;
    step();
    rst = 1'b0;
    dut_pops.delete();
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", key_valid); end
    checks++; if (key_any !== 1'b0)   begin errors++; $display("FAIL rstmid_any got=%b exp=0", key_any); end
    checks++; if (col_n !== 4'hF)     begin errors++; $display("FAIL rstmid_col_n got=%h exp=f", col_n); end
    key_ready = 1'b1;
    for (int i = 0; i < 5 * FRAME; i++) begin
      step();
      checks++;
      if ({col_n, key_valid, key_any, overflow} !== m_obs()) begin
        errors++; $display("FAIL rstmid_cycle k=%0d got=%b exp=%b", m_k, {col_n, key_valid, key_any, overflow}, m_obs());
      end
    end
    checks++;
    if (dut_pops.size() != 1 || dut_pops[0] != legend(2, 0)) begin
      errors++; $display("FAIL rstmid_rereport got_n=%0d exp_code=%0d", dut_pops.size(), legend(2, 0));
    end
    release_all();
  endtask

  task automatic test_random();
    int hold;
    apply_reset();
    for (int it = 0; it < 30; it++) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) kp[r][c] = ($urandom_range(0, 7) == 0);
      hold = $urandom_range(10, 4 * FRAME);
      for (int i = 0; i < hold; i++) begin
        key_ready = ($urandom_range(0, 3) != 0);
        step();
        checks++;
        if ({col_n, key_valid, key_any, overflow} !== m_obs()) begin
          errors++; $display("FAIL rand_cycle k=%0d got=%b exp=%b", m_k, {col_n, key_valid, key_any, overflow}, m_obs());
        end
        if (m_q.size() > 0) begin
          checks++;
          if (key_code !== CW'(m_q[0])) begin errors++; $display("FAIL rand_code k=%0d got=%h exp=%h", m_k, key_code, m_q[0]); end
        end
      end
    end
    release_all();
  endtask

  initial begin
    release_all();
    test_reset();
    test_idle();
    test_single_hold();
    test_glitch();
    test_overflow();
    test_simultaneous();
    test_hexmap_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
